// File: rtl/comparator_serial.sv
// comparator_serial: multi-cycle MSB-first magnitude comparator with early exit on the first differing slice.
module comparator_serial #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] lt_vec
);
    localparam int NSLICE = WIDTH / DIGIT;
    localparam int SW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [SW-1:0]    r_idx;
    logic [DIGIT-1:0] w_as, w_bs;
    logic             w_last;
    // Operands shift left each cycle so the slice under test is always the top DIGIT bits.
    assign w_as   = r_a[WIDTH-1 -: DIGIT];
    assign w_bs   = r_b[WIDTH-1 -: DIGIT];
    assign w_last = r_idx == '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = (w_as != w_bs || w_last) ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt_vec <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= SW'(NSLICE - 1);
        end else begin
            busy <= w_next == RUN;
            done <= w_next == DONE;
            if (r_state == IDLE && start) begin
                // Flipping both MSBs maps two's complement onto offset binary.
                r_a    <= {in1[WIDTH-1] ^ signed_mode, in1[WIDTH-2:0]};
                r_b    <= {in2[WIDTH-1] ^ signed_mode, in2[WIDTH-2:0]};
                lt_vec <= ~in1 & in2;
                lt     <= 1'b0;
                eq     <= 1'b0;
                gt     <= 1'b0;
                r_idx  <= SW'(NSLICE - 1);
            end else if (r_state == RUN) begin
                lt    <= w_as < w_bs;
                gt    <= w_as > w_bs;
                eq    <= w_as == w_bs && w_last;
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_idx <= r_idx - 1'b1;
            end
        end
    end
endmodule
